// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   In-order store FIFO between the execute stage and the data memory.
//   Stores are accepted from the pipeline and written to memory from the head
//   entry whenever the memory is not busy. A load is checked against every
//   pending store on its word address. A load that overlaps a pending store
//   stalls until that store has drained.
//
//   Optional feature (macro STORE_FWD_EN): store-to-load forwarding. When the
//   youngest matching entry is a word store and the load is a word load, the
//   load is satisfied from the buffer instead of stalling.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   st_valid/st_ready    store handshake; st_addr/st_data/st_size/st_pc payload
//   ld_valid/ld_addr/    load lookup request
//   ld_size
//   ld_stall             load conflicts with a pending store
//   ld_hit/ld_fwd_data   forwarding result (always 0 without STORE_FWD_EN)
//   mem_we/mem_addr/     head-entry write port to data memory
//   mem_data/mem_size/
//   mem_pc
//   mem_busy             memory cannot accept a write this cycle
//   count                number of valid entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    input  logic [1:0]             st_size,
    input  logic [31:0]            st_pc,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    input  logic [1:0]             ld_size,
    output logic                   ld_stall,
    output logic                   ld_hit,
    output logic [31:0]            ld_fwd_data,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_data,
    output logic [1:0]             mem_size,
    output logic [31:0]            mem_pc,
    input  logic                   mem_busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    logic [AW-1:0]   addr_q [DEPTH];
    logic [AW-1:0]   addr_d [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [1:0]      size_q [DEPTH];
    logic [1:0]      size_d [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic [31:0]     pc_d   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    logic            pop;
    logic [DEPTH-1:0] match;
    logic            any_match;

    // Reserved-size stores complete the handshake but never occupy an entry.
    assign st_ready = (count_q < DepthCnt);
    assign push     = st_valid && st_ready && (st_size != 2'd3);
    assign pop      = (count_q != '0) && !mem_busy;

    assign mem_we   = pop;
    assign mem_addr = addr_q[rd_ptr_q];
    assign mem_data = data_q[rd_ptr_q];
    assign mem_size = size_q[rd_ptr_q];
    assign mem_pc   = pc_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Clear before set: when full-then-pop is impossible with push in the
        // same cycle, the two indices can only coincide on an empty buffer.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            addr_d[wr_ptr_q]  = st_addr;
            data_d[wr_ptr_q]  = st_data;
            size_d[wr_ptr_q]  = st_size;
            pc_d[wr_ptr_q]    = st_pc;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Registered contents only: the head being drained still conflicts, and a
    // store being pushed this cycle is not yet visible.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (addr_q[i][AW-1:2] == ld_addr[AW-1:2]);
        end
    end
    assign any_match = |match;

`ifdef STORE_FWD_EN
    logic          fwd_found;
    logic [PW-1:0] fwd_idx;
    logic [PW-1:0] age_idx;
    logic          fwd_ok;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_found = 1'b0;
        fwd_idx   = '0;
        age_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx = rd_ptr_q + PW'(k);
            if (match[age_idx]) begin
                fwd_found = 1'b1;
                fwd_idx   = age_idx;
            end
        end
    end

    assign fwd_ok      = ld_valid && fwd_found && (size_q[fwd_idx] == 2'd0) && (ld_size == 2'd0);
    assign ld_hit      = fwd_ok;
    assign ld_fwd_data = fwd_ok ? data_q[fwd_idx] : 32'd0;
    assign ld_stall    = ld_valid && any_match && !fwd_ok;
`else
    assign ld_hit      = 1'b0;
    assign ld_fwd_data = 32'd0;
    assign ld_stall    = ld_valid && any_match;
`endif

    // Byte offset never takes part in the word compare; load size only matters
    // for forwarding.
    logic unused_ld;
    assign unused_ld = ^{ld_addr[1:0], ld_size};

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL provide parameter: DEPTH, default 4, number of store entries (power of 2, 2..16).
REQ-002 SHALL provide parameter: AW, default 12, byte-address width matching the data memory address port.
REQ-003 SHALL provide ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from execute stage.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  AW  store byte address.
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_size  in  2  0=word (sw), 1=byte (sb), 2=half (sh), 3=reserved.
- st_pc  in  32  PC of the store, carried for memory trace output.
- ld_valid  in  1  load lookup request.
- ld_addr  in  AW  load byte address.
- ld_size  in  2  load size, same encoding as st_size.
- ld_stall  out  1  load must wait; conflicting store pending.
- ld_hit  out  1  load satisfied by forwarding (STORE_FWD_EN only).
- ld_fwd_data  out  32  forwarded word.
- mem_we  out  1  write strobe to data memory.
- mem_addr  out  AW  head-entry address.
- mem_data  out  32  head-entry data.
- mem_size  out  2  head-entry size (drives memory size select).
- mem_pc  out  32  head-entry PC.
- mem_busy  in  1  memory cannot accept a write this cycle.
- count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-004 SHALL operate as an in-order FIFO of {addr, data, size, pc}; drain order equals accept order.
REQ-005 SHALL assert st_ready = (count < DEPTH); a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-006 SHALL push on rising edge when st_valid && st_ready && st_size != 3.
REQ-007 SHALL accept and discard a store with st_size == 3: st_ready unaffected, no entry, count unchanged.
REQ-008 SHALL drive mem_addr/mem_data/mem_size/mem_pc from the head entry, combinationally from registers.
REQ-009 SHALL assert mem_we = (count != 0) && !mem_busy; pop the head on the same rising edge.
REQ-010 SHALL have a minimum latency of 1 cycle: a store pushed at edge N drives mem_we in cycle N+1 at the earliest.
REQ-011 SHALL, on simultaneous push and pop, leave count unchanged and keep both pointers advancing.
REQ-012 SHALL wrap read/write pointers modulo DEPTH without a gap entry.
REQ-013 SHALL compare a load against every valid entry on word address (addr[AW-1:2]), using pre-edge contents only; a store pushed in the same cycle is not compared.
REQ-014 SHALL count the head entry being drained this cycle as conflicting.
REQ-015 SHALL assert ld_stall = ld_valid && any match (except REQ-021); ld_stall SHALL be 0 when ld_valid == 0 or count == 0.
REQ-016 SHALL hold ld_hit = 0 and ld_fwd_data = 0 when forwarding is not compiled in.

Reset
REQ-017 SHALL, while reset == 0, immediately clear pointers, count, and all entry-valid bits; pending stores SHALL be lost.
REQ-018 SHALL drive reset values: mem_we=0, count=0, st_ready=1, ld_stall=0, ld_hit=0, ld_fwd_data=0; mem_addr/mem_data/mem_size/mem_pc=0.
REQ-019 SHALL drop mem_we asynchronously when reset asserts mid-drain; the interrupted write is not retried.

Configuration
REQ-020 SHALL use macro STORE_FWD_EN to compile store-to-load forwarding in or out.
REQ-021 SHALL, with STORE_FWD_EN defined, select the youngest matching entry; if that entry has size 0 and ld_size == 0, assert ld_hit=1, ld_fwd_data=entry data, ld_stall=0; otherwise stall per REQ-015.
REQ-022 SHALL, without STORE_FWD_EN, implement no forwarding logic; ld_hit stays 0 and every match stalls.

Verification
REQ-023 Push sw addr 0x010 data 0xDEADBEEF, mem_busy=0 -> mem_we=1 next cycle with mem_addr=0x010, mem_data=0xDEADBEEF, mem_size=0; count returns to 0.
REQ-024 mem_busy=1, push 5 stores (DEPTH=4) -> st_ready=0 after 4th, count=4, 5th not accepted; release busy -> 4 writes drain in order over 4 cycles.
REQ-025 Buffer holds sb 0x021; lw 0x020 -> ld_stall=1; lw 0x024 -> ld_stall=0.
REQ-026 STORE_FWD_EN: sw 0x040 0x11111111 then sw 0x040 0x22222222, busy=1; lw 0x040 -> ld_hit=1, ld_fwd_data=0x22222222, ld_stall=0; lhu 0x040 -> ld_stall=1.
REQ-027 3 entries pending with mem_we=1, assert reset mid-cycle -> mem_we=0 immediately, count=0, st_ready=1; no further writes after release.
REQ-028 Full buffer, mem_busy=0 with st_valid=1 -> pop occurs, st_ready stays 0 that cycle, push accepted the following cycle; st_size=3 store -> count unchanged.
